// File: rtl/bus_pkg.sv
// Shared widths and the read-check pipeline entry for the bus scoreboard.
// Entry fields are sized for the widest supported bus; narrower buses zero-extend.
package bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;
  localparam int RD_LAT_DEF = 0;
  localparam int CNT_W_DEF  = 16;
  localparam int RD_LAT_MAX = 4;

  localparam int ADDR_W_MAX = 32;
  localparam int DATA_W_MAX = 128;
  localparam int MASK_W_MAX = DATA_W_MAX / 8;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] exp;
    logic [MASK_W_MAX-1:0] mask;
    logic                  vld;
  } chk_entry_t;

endpackage

// File: rtl/sb_rd_pipe.sv
// Delay line that carries read snapshots from acceptance to the rdata sample point.
// Reset empties every stage so pending checks are dropped.
module sb_rd_pipe
  import bus_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  chk_entry_t i_ent,
  output chk_entry_t o_ent
);

  chk_entry_t r_stage [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_ent;
      for (int s = 1; s < LAT; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_ent = r_stage[LAT-1];

endmodule

// File: rtl/bus_scoreboard_p.sv
// Passive bus checker: shadows written bytes, checks read data after RD_LAT cycles,
// and keeps saturating statistics plus a capture of the first failing read.
module bus_scoreboard_p
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                i_ready,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic                i_clr,
  output logic                o_mismatch,
  output logic                o_error,
  output logic [CNT_W-1:0]    o_wr_cnt,
  output logic [CNT_W-1:0]    o_rd_chk_cnt,
  output logic [CNT_W-1:0]    o_rd_unk_cnt,
  output logic [CNT_W-1:0]    o_mis_cnt,
  output logic [CNT_W-1:0]    o_oor_cnt,
  output logic [ADDR_W-1:0]   o_first_addr,
  output logic [DATA_W-1:0]   o_first_exp,
  output logic [DATA_W-1:0]   o_first_got
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]     DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W_MAX-1:0] DEPTH_X = ADDR_W_MAX'(DEPTH);

  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [NB-1:0]     r_known  [DEPTH];

  logic              r_mismatch;
  logic              r_error;
  logic              r_captured;
  logic [CNT_W-1:0]  r_wrCnt;
  logic [CNT_W-1:0]  r_rdChkCnt;
  logic [CNT_W-1:0]  r_rdUnkCnt;
  logic [CNT_W-1:0]  r_misCnt;
  logic [CNT_W-1:0]  r_oorCnt;
  logic [ADDR_W-1:0] r_firstAddr;
  logic [DATA_W-1:0] r_firstExp;
  logic [DATA_W-1:0] r_firstGot;

  logic                  w_accept;
  logic                  w_inRange;
  logic                  w_wrHit;
  logic                  w_rdHit;
  logic                  w_oorHit;
  logic [IDX_W-1:0]      w_idx;
  chk_entry_t            w_entIn;
  chk_entry_t            w_exit;
  logic [DATA_W_MAX-1:0] w_got;
  logic                  w_fail;
  logic [DATA_W-1:0]     w_expMasked;
  logic                  w_exitInRange;
  logic                  w_doCheck;
  logic                  w_unk;
  logic                  w_chkHit;
  logic                  w_unkHit;
  logic                  w_misHit;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept  = i_valid & i_ready;
  assign w_inRange = ({1'b0, i_addr} < DEPTH_L);
  assign w_wrHit   = w_accept & i_wr_en & w_inRange;
  assign w_rdHit   = w_accept & ~i_wr_en & w_inRange;
  assign w_oorHit  = w_accept & ~w_inRange;
  assign w_idx     = i_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (w_wrHit) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) begin
          r_shadow[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_known[i] <= '0;
      end
    end else if (w_wrHit) begin
      r_known[w_idx] <= r_known[w_idx] | i_wstrb;
    end
  end

  // The snapshot is taken before any later write can touch the shadow entry.
  always_comb begin
    w_entIn      = '0;
    w_entIn.addr = ADDR_W_MAX'(i_addr);
    w_entIn.exp  = DATA_W_MAX'(r_shadow[w_idx]);
    w_entIn.mask = MASK_W_MAX'(r_known[w_idx]);
    w_entIn.vld  = w_rdHit;
  end

  if (RD_LAT == 0) begin : g_noPipe
    assign w_exit = w_entIn;
  end else begin : g_pipe
    sb_rd_pipe #(
      .LAT (RD_LAT)
    ) u_rdPipe (
      .clk   (clk),
      .rst   (rst),
      .i_ent (w_entIn),
      .o_ent (w_exit)
    );
  end

  assign w_got = DATA_W_MAX'(i_rdata);

  // Case inequality so that undriven or unknown bytes on a known lane count as failures.
  always_comb begin
    w_fail = 1'b0;
    for (int b = 0; b < MASK_W_MAX; b++) begin
      if (w_exit.mask[b] && (w_exit.exp[8*b +: 8] !== w_got[8*b +: 8])) begin
        w_fail = 1'b1;
      end
    end
  end

  always_comb begin
    w_expMasked = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_exit.mask[b]) begin
        w_expMasked[8*b +: 8] = w_exit.exp[8*b +: 8];
      end
    end
  end

  assign w_exitInRange = (w_exit.addr < DEPTH_X);
  assign w_doCheck     = w_exit.vld & w_exitInRange & ~i_clr;
  assign w_unk         = (w_exit.mask == '0);
  assign w_chkHit      = w_doCheck & ~w_unk;
  assign w_unkHit      = w_doCheck & w_unk;
  assign w_misHit      = w_chkHit & w_fail;

  // A clear wins over every event in the same cycle, including a completing check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch  <= 1'b0;
      r_error     <= 1'b0;
      r_captured  <= 1'b0;
      r_wrCnt     <= '0;
      r_rdChkCnt  <= '0;
      r_rdUnkCnt  <= '0;
      r_misCnt    <= '0;
      r_oorCnt    <= '0;
      r_firstAddr <= '0;
      r_firstExp  <= '0;
      r_firstGot  <= '0;
    end else if (i_clr) begin
      r_mismatch  <= 1'b0;
      r_error     <= 1'b0;
      r_captured  <= 1'b0;
      r_wrCnt     <= '0;
      r_rdChkCnt  <= '0;
      r_rdUnkCnt  <= '0;
      r_misCnt    <= '0;
      r_oorCnt    <= '0;
      r_firstAddr <= '0;
      r_firstExp  <= '0;
      r_firstGot  <= '0;
    end else begin
      r_mismatch <= w_misHit;
      if (w_wrHit)  r_wrCnt    <= satInc(r_wrCnt);
      if (w_oorHit) r_oorCnt   <= satInc(r_oorCnt);
      if (w_chkHit) r_rdChkCnt <= satInc(r_rdChkCnt);
      if (w_unkHit) r_rdUnkCnt <= satInc(r_rdUnkCnt);
      if (w_misHit) r_misCnt   <= satInc(r_misCnt);
      if (w_oorHit || w_misHit) r_error <= 1'b1;
      if (w_misHit && !r_captured) begin
        r_captured  <= 1'b1;
        r_firstAddr <= w_exit.addr[ADDR_W-1:0];
        r_firstExp  <= w_expMasked;
        r_firstGot  <= i_rdata;
      end
    end
  end

  assign o_mismatch   = r_mismatch;
  assign o_error      = r_error;
  assign o_wr_cnt     = r_wrCnt;
  assign o_rd_chk_cnt = r_rdChkCnt;
  assign o_rd_unk_cnt = r_rdUnkCnt;
  assign o_mis_cnt    = r_misCnt;
  assign o_oor_cnt    = r_oorCnt;
  assign o_first_addr = r_firstAddr;
  assign o_first_exp  = r_firstExp;
  assign o_first_got  = r_firstGot;

endmodule

// File: tb/tb_bus_scoreboard_p.sv
// Directed bench for bus_scoreboard_p: instance A uses defaults (RD_LAT=0),
// instance B uses RD_LAT=2, DEPTH=200, CNT_W=4; both snoop the same bus.
module tb_bus_scoreboard_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready, wrEn, clr;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  logic        aMismatch, aError;
  logic [15:0] aWrCnt, aRdChk, aRdUnk, aMisCnt, aOorCnt;
  logic [7:0]  aFirstAddr;
  logic [31:0] aFirstExp, aFirstGot;

  logic        bMismatch, bError;
  logic [3:0]  bWrCnt, bRdChk, bRdUnk, bMisCnt, bOorCnt;
  logic [7:0]  bFirstAddr;
  logic [31:0] bFirstExp, bFirstGot;

  int tests = 0;
  int fails = 0;
  int aPulses = 0;
  int bPulses = 0;

  bus_scoreboard_p u_dutA (
    .clk(clk), .rst(rst), .i_valid(valid), .i_ready(ready), .i_wr_en(wrEn),
    .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb), .i_rdata(rdata), .i_clr(clr),
    .o_mismatch(aMismatch), .o_error(aError), .o_wr_cnt(aWrCnt),
    .o_rd_chk_cnt(aRdChk), .o_rd_unk_cnt(aRdUnk), .o_mis_cnt(aMisCnt),
    .o_oor_cnt(aOorCnt), .o_first_addr(aFirstAddr), .o_first_exp(aFirstExp),
    .o_first_got(aFirstGot)
  );

  bus_scoreboard_p #(.RD_LAT(2), .DEPTH(200), .CNT_W(4)) u_dutB (
    .clk(clk), .rst(rst), .i_valid(valid), .i_ready(ready), .i_wr_en(wrEn),
    .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb), .i_rdata(rdata), .i_clr(clr),
    .o_mismatch(bMismatch), .o_error(bError), .o_wr_cnt(bWrCnt),
    .o_rd_chk_cnt(bRdChk), .o_rd_unk_cnt(bRdUnk), .o_mis_cnt(bMisCnt),
    .o_oor_cnt(bOorCnt), .o_first_addr(bFirstAddr), .o_first_exp(bFirstExp),
    .o_first_got(bFirstGot)
  );

  always #5 clk = ~clk;

  // Mismatch pulses are counted on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (aMismatch === 1'b1) aPulses++;
    if (bMismatch === 1'b1) bPulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; ready = 1'b1; wrEn = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    valid = 1'b0; wrEn = 1'b0;
  endtask

  task automatic busRead(input logic [7:0] a, input logic [31:0] r);
    valid = 1'b1; ready = 1'b1; wrEn = 1'b0; addr = a; rdata = r;
    tick();
    valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests++; if (aError !== 1'b0) begin fails++; $display("[TB] FAIL reset_a_error got %0h exp 0", aError); end
    tests++; if (aWrCnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_a_wr_cnt got %0h exp 0", aWrCnt); end
    tests++; if (aFirstExp !== 32'd0) begin fails++; $display("[TB] FAIL reset_a_first_exp got %0h exp 0", aFirstExp); end
    tests++; if (bMismatch !== 1'b0) begin fails++; $display("[TB] FAIL reset_b_mismatch got %0h exp 0", bMismatch); end
    tests++; if (bOorCnt !== 4'd0) begin fails++; $display("[TB] FAIL reset_b_oor_cnt got %0h exp 0", bOorCnt); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int p0;
    p0 = aPulses;
    valid = 1'b1; ready = 1'b0; wrEn = 1'b1; addr = 8'h10; wdata = 32'h12345678; wstrb = 4'hF;
    tick();
    valid = 1'b0; ready = 1'b1; wrEn = 1'b0;
    tests++; if (aWrCnt !== 16'd0) begin fails++; $display("[TB] FAIL basic_no_ready got %0h exp 0", aWrCnt); end
    busWrite(8'h10, 32'hDEADBEEF, 4'hF);
    busRead(8'h10, 32'hDEADBEEF);
    tick();
    tests++; if (aWrCnt !== 16'd1) begin fails++; $display("[TB] FAIL basic_wr_cnt got %0h exp 1", aWrCnt); end
    tests++; if (aRdChk !== 16'd1) begin fails++; $display("[TB] FAIL basic_rd_chk got %0h exp 1", aRdChk); end
    tests++; if (aError !== 1'b0) begin fails++; $display("[TB] FAIL basic_error got %0h exp 0", aError); end
    tests++; if (aPulses != p0) begin fails++; $display("[TB] FAIL basic_pulses got %0d exp %0d", aPulses, p0); end
  endtask

  task automatic test_mismatch();
    int p0;
    p0 = aPulses;
    busRead(8'h10, 32'hDEADBEEE);
    tests++; if (aMismatch !== 1'b1) begin fails++; $display("[TB] FAIL mis_pulse_hi got %0h exp 1", aMismatch); end
    tick();
    tests++; if (aMismatch !== 1'b0) begin fails++; $display("[TB] FAIL mis_pulse_lo got %0h exp 0", aMismatch); end
    tests++; if (aPulses - p0 != 1) begin fails++; $display("[TB] FAIL mis_pulse_count got %0d exp 1", aPulses - p0); end
    tests++; if (aMisCnt !== 16'd1) begin fails++; $display("[TB] FAIL mis_cnt got %0h exp 1", aMisCnt); end
    tests++; if (aError !== 1'b1) begin fails++; $display("[TB] FAIL mis_error got %0h exp 1", aError); end
    tests++; if (aFirstAddr !== 8'h10) begin fails++; $display("[TB] FAIL mis_first_addr got %0h exp 10", aFirstAddr); end
    tests++; if (aFirstExp !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL mis_first_exp got %0h exp deadbeef", aFirstExp); end
    tests++; if (aFirstGot !== 32'hDEADBEEE) begin fails++; $display("[TB] FAIL mis_first_got got %0h exp deadbeee", aFirstGot); end
    busRead(8'h10, 32'h00000000);
    tick();
    tests++; if (aMisCnt !== 16'd2) begin fails++; $display("[TB] FAIL mis_cnt2 got %0h exp 2", aMisCnt); end
    tests++; if (aFirstGot !== 32'hDEADBEEE) begin fails++; $display("[TB] FAIL mis_capture_held got %0h exp deadbeee", aFirstGot); end
    tests++; if (aRdChk !== 16'd3) begin fails++; $display("[TB] FAIL mis_rd_chk got %0h exp 3", aRdChk); end
  endtask

  task automatic test_strobe();
    doReset();
    busWrite(8'h20, 32'h000000AA, 4'b0001);
    busRead(8'h20, 32'h123456AA);
    tests++; if (aMismatch !== 1'b0) begin fails++; $display("[TB] FAIL strb_partial_pass got %0h exp 0", aMismatch); end
    tests++; if (aRdChk !== 16'd1) begin fails++; $display("[TB] FAIL strb_rd_chk got %0h exp 1", aRdChk); end
    busRead(8'h21, 32'h0);
    tests++; if (aRdUnk !== 16'd1) begin fails++; $display("[TB] FAIL strb_rd_unk got %0h exp 1", aRdUnk); end
    busWrite(8'h22, 32'hFFFFFFFF, 4'b0000);
    tests++; if (aWrCnt !== 16'd2) begin fails++; $display("[TB] FAIL strb_zero_wr_cnt got %0h exp 2", aWrCnt); end
    busRead(8'h22, 32'h0);
    tests++; if (aRdUnk !== 16'd2) begin fails++; $display("[TB] FAIL strb_zero_unk got %0h exp 2", aRdUnk); end
    busRead(8'h20, 32'h123456AB);
    tests++; if (aMismatch !== 1'b1) begin fails++; $display("[TB] FAIL strb_byte0_mis got %0h exp 1", aMismatch); end
    tests++; if (aFirstExp !== 32'h000000AA) begin fails++; $display("[TB] FAIL strb_first_exp got %0h exp aa", aFirstExp); end
    tests++; if (aFirstGot !== 32'h123456AB) begin fails++; $display("[TB] FAIL strb_first_got got %0h exp 123456ab", aFirstGot); end
  endtask

  task automatic test_snapshot();
    doReset();
    busWrite(8'h30, 32'h11111111, 4'hF);
    busRead(8'h30, 32'h0);
    busWrite(8'h30, 32'h22222222, 4'hF);
    rdata = 32'h11111111;
    tick();
    tests++; if (bMismatch !== 1'b0) begin fails++; $display("[TB] FAIL snap_mismatch got %0h exp 0", bMismatch); end
    tests++; if (bRdChk !== 4'd1) begin fails++; $display("[TB] FAIL snap_rd_chk got %0h exp 1", bRdChk); end
    tests++; if (bWrCnt !== 4'd2) begin fails++; $display("[TB] FAIL snap_wr_cnt got %0h exp 2", bWrCnt); end
    busRead(8'h30, 32'h0);
    tests++; if (bMismatch !== 1'b0) begin fails++; $display("[TB] FAIL lat_edge1 got %0h exp 0", bMismatch); end
    tick();
    tests++; if (bMismatch !== 1'b0) begin fails++; $display("[TB] FAIL lat_edge2 got %0h exp 0", bMismatch); end
    tick();
    tests++; if (bMismatch !== 1'b1) begin fails++; $display("[TB] FAIL lat_edge3 got %0h exp 1", bMismatch); end
    tests++; if (bFirstExp !== 32'h22222222) begin fails++; $display("[TB] FAIL lat_first_exp got %0h exp 22222222", bFirstExp); end
    tests++; if (bFirstAddr !== 8'h30) begin fails++; $display("[TB] FAIL lat_first_addr got %0h exp 30", bFirstAddr); end
  endtask

  task automatic test_oor_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (bError !== 1'b0) begin fails++; $display("[TB] FAIL clr_error got %0h exp 0", bError); end
    tests++; if (bFirstExp !== 32'h0) begin fails++; $display("[TB] FAIL clr_first_exp got %0h exp 0", bFirstExp); end
    busWrite(8'hC7, 32'h5A5A5A5A, 4'hF);
    tests++; if (bWrCnt !== 4'd1) begin fails++; $display("[TB] FAIL oor_last_in_range got %0h exp 1", bWrCnt); end
    busWrite(8'hC8, 32'h5A5A5A5A, 4'hF);
    tests++; if (bOorCnt !== 4'd1) begin fails++; $display("[TB] FAIL oor_first_out got %0h exp 1", bOorCnt); end
    tests++; if (bWrCnt !== 4'd1) begin fails++; $display("[TB] FAIL oor_wr_unchanged got %0h exp 1", bWrCnt); end
    tests++; if (bError !== 1'b1) begin fails++; $display("[TB] FAIL oor_error got %0h exp 1", bError); end
    busRead(8'hF0, 32'h0);
    tick();
    tick();
    tests++; if (bOorCnt !== 4'd2) begin fails++; $display("[TB] FAIL oor_read got %0h exp 2", bOorCnt); end
    tests++; if (bRdChk !== 4'd0 || bRdUnk !== 4'd0) begin fails++; $display("[TB] FAIL oor_read_nocheck got %0h/%0h exp 0/0", bRdChk, bRdUnk); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (bOorCnt !== 4'd0 || bWrCnt !== 4'd0) begin fails++; $display("[TB] FAIL clr_counters got %0h/%0h exp 0/0", bOorCnt, bWrCnt); end
    busRead(8'h30, 32'h0);
    tick();
    rdata = 32'h22222222;
    tick();
    tests++; if (bRdChk !== 4'd1) begin fails++; $display("[TB] FAIL clr_shadow_kept got %0h exp 1", bRdChk); end
    tests++; if (bError !== 1'b0) begin fails++; $display("[TB] FAIL clr_good_error got %0h exp 0", bError); end
    busRead(8'h30, 32'h0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (bMismatch !== 1'b0 || bMisCnt !== 4'd0) begin fails++; $display("[TB] FAIL clr_discard got %0h/%0h exp 0/0", bMismatch, bMisCnt); end
  endtask

  task automatic test_saturate();
    doReset();
    valid = 1'b1; ready = 1'b1; wrEn = 1'b1; addr = 8'h01; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    repeat (20) tick();
    valid = 1'b0; wrEn = 1'b0;
    tests++; if (bWrCnt !== 4'hF) begin fails++; $display("[TB] FAIL sat_b_wr_cnt got %0h exp f", bWrCnt); end
    tests++; if (aWrCnt !== 16'd20) begin fails++; $display("[TB] FAIL sat_a_wr_cnt got %0h exp 14", aWrCnt); end
  endtask

  task automatic test_reset_midread();
    int p0;
    doReset();
    busWrite(8'h40, 32'h33333333, 4'hF);
    p0 = bPulses;
    busRead(8'h40, 32'h0);
    rst = 1'b1;
    #1;
    tests++; if (bWrCnt !== 4'd0 || bError !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_async got %0h/%0h exp 0/0", bWrCnt, bError); end
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tests++; if (bPulses != p0) begin fails++; $display("[TB] FAIL rstmid_pulses got %0d exp %0d", bPulses, p0); end
    tests++; if (bMisCnt !== 4'd0 || bRdChk !== 4'd0) begin fails++; $display("[TB] FAIL rstmid_counts got %0h/%0h exp 0/0", bMisCnt, bRdChk); end
    busRead(8'h40, 32'h0);
    tick();
    tick();
    tests++; if (bRdUnk !== 4'd1) begin fails++; $display("[TB] FAIL rstmid_known_cleared got %0h exp 1", bRdUnk); end
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; ready = 1'b1; wrEn = 1'b0; clr = 1'b0;
    addr = '0; wdata = '0; rdata = '0; wstrb = '0;
    test_reset();
    test_basic();
    test_mismatch();
    test_strobe();
    test_snapshot();
    test_oor_clr();
    test_saturate();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/bus_scoreboard_p.md
Name: bus_scoreboard_p

Overview:
Parametrised passive checker that snoops the shared valid/ready bus and keeps a shadow copy of every byte written. Read data is checked against that shadow copy after a configurable read latency. Beyond the earlier checker, it adds byte strobes, per-byte known tracking, and out-of-range detection. It also adds saturating statistics counters, a sticky error flag, and first-mismatch capture. It sits beside the manager/slave pair in the testbench/SoC top and never drives the bus.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 32, data width; multiple of 8
DEPTH, 256, shadow entries; addresses >= DEPTH are out of range
RD_LAT, 0, cycles from read acceptance to rdata valid (0..4)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous active-high reset
valid  in  1  bus request valid
ready  in  1  bus request ready; accept = valid & ready
wr_en  in  1  1 = write, 0 = read
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte write enables
rdata  in  DATA_W  read data, valid RD_LAT cycles after read accept
clr  in  1  synchronous clear of counters, error flag, capture (shadow kept)
mismatch  out  1  one-cycle pulse per failing read check
error  out  1  sticky: any mismatch or out-of-range since reset/clr
wr_cnt  out  CNT_W  accepted in-range writes, saturating
rd_chk_cnt  out  CNT_W  in-range reads that checked >=1 known byte, saturating
rd_unk_cnt  out  CNT_W  in-range reads with no known bytes, saturating
mis_cnt  out  CNT_W  mismatching reads, saturating
oor_cnt  out  CNT_W  out-of-range accepts, saturating
first_addr  out  ADDR_W  address of first mismatch since reset/clr
first_exp  out  DATA_W  expected data of first mismatch (unknown bytes 0)
first_got  out  DATA_W  rdata of first mismatch

Behaviour:
- Reset (async): all outputs 0; all per-byte known bits 0; read pipeline emptied. Shadow data array is not reset.
- Write accept, addr < DEPTH: on the same edge, for each byte with wstrb=1, update the shadow byte and set its known bit. Increment wr_cnt. wstrb=0 is legal, counts as a write, and changes nothing.
- Read accept, addr < DEPTH: snapshot {addr, shadow data, known mask} into stage 0 of an RD_LAT-deep pipeline.
  - With RD_LAT=0, the check uses the current rdata in the accept cycle.
  - Otherwise, the check happens when the entry exits the pipeline and samples rdata that cycle.
  - A write to the same address accepted between the read and its check does not alter the snapshot.
- Check: compare only known bytes, using case inequality, so X or Z on a known byte fails.
  - Mask all-zero: increment rd_unk_cnt, no compare.
  - Otherwise increment rd_chk_cnt. On failure, register mismatch=1 for one cycle, increment mis_cnt and set error.
  - If this is the first failure since reset/clr, load first_addr/exp/got.
- Output timing: mismatch and counters update on the edge after the check cycle. Observed latency from read accept to mismatch is RD_LAT+1 edges.
- Out of range (addr >= DEPTH, read or write): no shadow update, no check, increment oor_cnt, set error.
- Pipeline occupancy: one accept per cycle, so the pipeline never overflows. Non-read cycles insert bubbles.
- Saturation: every counter holds at 2^CNT_W-1.
- clr: counters, error and capture return to 0 next edge. A check completing in the same cycle as clr is discarded. Known bits and pipeline contents are preserved.
- Reset mid-read: pending checks are dropped, no mismatch emitted.

Decomposition:
- Package bus_pkg: add localparams for default widths, RD_LAT_MAX=4, and a typedef chk_entry_t {addr, exp, mask, vld}.
- One sub-module, sb_rd_pipe: a parametrised RD_LAT-stage shift register of chk_entry_t with async reset clearing vld.
- Shadow array, counters and capture stay in bus_scoreboard_p.

Test Plan:
- RD_LAT=0. Write 0x10=0xDEADBEEF (wstrb=F), then read 0x10 with rdata=0xDEADBEEF -> wr_cnt=1, rd_chk_cnt=1, mismatch never pulses, error=0.
- Read 0x10 with rdata=0xDEADBEEE -> mismatch pulses once, mis_cnt=1, error=1, first_addr=0x10, first_exp=0xDEADBEEF, first_got=0xDEADBEEE. A second mismatch leaves the capture unchanged.
- Fresh reset. Write 0x20=0x000000AA with wstrb=0001, then read 0x20 with rdata=0x123456AA -> pass, since only byte 0 is compared. Read unwritten 0x21 -> rd_unk_cnt=1.
- RD_LAT=2. Read 0x30 (expected 0x11111111), then write 0x30=0x22222222 next cycle. Drive rdata=0x11111111 two cycles after the read -> pass, confirming snapshot semantics. Mismatch on bad data appears exactly 3 edges after accept.
- DEPTH=200. Write to 0xF0 -> oor_cnt=1, error=1, wr_cnt unchanged. Pulse clr -> all counters 0, error 0; a subsequent read of earlier data still checks correctly.
- CNT_W=4. Issue 20 writes -> wr_cnt=15. Assert rst during a pending RD_LAT=2 read with bad data -> no mismatch, all outputs 0.
